mining_controller: RTL and testbench
====================================

# mining_controller

Parametrised top-level sequencing controller for the multi-core miner. It walks a job through midstate load, remaining-header load, parallel nonce search across `NUM_CORES` hash cores, and claim verification. Beyond the single-core controller it adds:
- built-in word counting and a word handshake;
- a shared nonce counter with exhaustion detection;
- round-robin arbitration of simultaneous claims;
- resume-on-failed-verify and abort.

It sits between the host/job interface and the hash-core array.

## Interface
Parameters:
- `NUM_CORES`, 4: hash cores; power of two, 1..64.
- `NONCE_W`, 32: nonce width.
- `MIDSTATE_WORDS`, 8: words in the midstate load.
- `REMAIN_WORDS`, 3: words in the remaining-header load.
- `VERIFY_TIMEOUT`, 1024: verify watchdog limit in cycles; used only with `MINER_VERIFY_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock. One clock domain; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a job; honoured only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `word_valid` in 1: header word present on the job interface.
- `word_ready` out 1: high in LOAD_MID and LOAD_REM.
- `load_mid_en` out 1: the accepted word belongs to the midstate.
- `load_rem_en` out 1: the accepted word belongs to the remaining header.
- `word_idx` out `$clog2(max(MIDSTATE_WORDS,REMAIN_WORDS))`: index of the current word.
- `solve_en` out 1: cores hash; high only in SOLVE.
- `nonce_base` out `NONCE_W`: core i hashes `nonce_base+i`.
- `core_claim` in `NUM_CORES`: per-core "target met" flags.
- `halt` out 1: high in HALT.
- `grant_idx` out `$clog2(NUM_CORES)` (min 1): core under verification.
- `claim_nonce` out `NONCE_W`: nonce under verification.
- `verify_done` in 1: verifier finished.
- `verify_pass` in 1: verifier result; qualified by `verify_done`.
- `sol_valid` out 1: one-cycle pulse, solution accepted.
- `exhausted` out 1: one-cycle pulse, nonce space swept without a solution.
- `cur_state` out 3: encoded state.

## Operation
State encoding: IDLE=0, LOAD_MID=1, LOAD_REM=2, SOLVE=3, HALT=4.

- **IDLE:** on `start`, clear `nonce_base`, the word counter and the core mask, then go to LOAD_MID.
- **LOAD_MID:** a word is accepted when `word_valid && word_ready`; `word_idx` then increments. On acceptance with `word_idx==MIDSTATE_WORDS-1`, clear the counter and go to LOAD_REM.
- **LOAD_REM:** same handshake. On acceptance of word `REMAIN_WORDS-1`, go to SOLVE.
- **SOLVE:**
  - Effective claims: `core_claim & ~mask`.
  - If any effective claim is present, grant round-robin: the first set bit at or above `rr_ptr`, wrapping. Latch `grant_idx` and `claim_nonce=nonce_base+grant_idx` (modulo 2^NONCE_W), then go to HALT. `nonce_base` does not advance that cycle.
  - Otherwise `nonce_base += NUM_CORES` and the mask clears. If that addition carries out of `NONCE_W`, pulse `exhausted` and go to IDLE.
- **HALT:** wait for `verify_done`.
  - Pass: pulse `sol_valid`, go to IDLE.
  - Fail: set `mask[grant_idx]`, set `rr_ptr=grant_idx+1` (wrapping), return to SOLVE with `nonce_base` unchanged. Other cores' pending claims at the same nonce are therefore served next.
- **abort:** has priority over every transition; the next state is IDLE with no pulses.
- **start outside IDLE:** ignored.

## Timing
- **Reset values:** every output is 0; `cur_state`=IDLE; `rr_ptr`=0; mask=0.
- **Registered outputs:** all outputs are registered and reflect the state entered at the clock edge.
- **Handshake:** with `word_valid` held high, the word stream completes in `MIDSTATE_WORDS+REMAIN_WORDS` cycles.
- **Claim to halt:** a claim sampled in SOLVE at edge N gives `halt`=1 after edge N.
- **Sampling window:** `core_claim` is sampled only in SOLVE; `verify_done` only in HALT.
- **Simultaneous claim and overflow:** the claim wins and no `exhausted` pulse is produced. Exhaustion is evaluated again after resume.
- **`verify_done` with `abort` in the same cycle:** abort wins; no `sol_valid`.
- **Pulse width:** `sol_valid` and `exhausted` are exactly one cycle, asserted in the first IDLE cycle.
- **Mid-operation reset:** an asynchronous `rst` mid-job returns to IDLE immediately. No pulse is generated.

## Configuration
Macro: `MINER_VERIFY_TIMEOUT_EN`.
- **Defined:** a counter runs in HALT. If `VERIFY_TIMEOUT` cycles elapse without `verify_done`, the block treats the claim as a failed verify (mask, advance, resume SOLVE).
- **Undefined:** HALT waits indefinitely and no counter is synthesised.

## Structure
- **Package `miner_pkg`:** the `state_t` enum (3-bit encoding above) and the `CUR_STATE_W` constant.
- **Sub-module `rr_arbiter`:** parametrised by `NUM_CORES`. Inputs: request vector and `rr_ptr`. Outputs: `grant_idx` and `any_grant`; purely combinational. The FSM, counters and mask stay in `mining_controller`.

## Test plan
- **Load:** `start`, then 11 back-to-back words → `load_mid_en` for idx 0..7, `load_rem_en` for idx 0..2, SOLVE in cycle 12, `nonce_base` steps 0, 4, 8.
- **Multi-claim:** at `nonce_base`=0x40, `core_claim`=4'b1010 → grant 1, `claim_nonce`=0x41. Fail → grant 3, `claim_nonce`=0x43. Pass → `sol_valid` pulse, IDLE.
- **Exhaustion:** `NONCE_W`=8, `NUM_CORES`=4, no claims → `exhausted` after 64 SOLVE cycles; `nonce_base` wraps to 0, IDLE.
- **Simultaneous claim and overflow:** claim at `nonce_base`=0xFC (`NONCE_W`=8) → HALT, no `exhausted`. Fail → `exhausted` on the next SOLVE cycle.
- **Abort:** `abort` in LOAD_REM at idx 1, and separately in HALT together with `verify_done`&`pass` → IDLE, no `sol_valid`. A later `start` reloads from idx 0.
- **Timeout (`MINER_VERIFY_TIMEOUT_EN`, `VERIFY_TIMEOUT`=16):** no `verify_done` → SOLVE resumes 16 cycles after entering HALT, with the granted core masked.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: state encoding shared by the miner sequencing controller.
package miner_pkg;

  localparam int CUR_STATE_W = 3;

  typedef enum logic [CUR_STATE_W-1:0] {
    IDLE     = 3'd0,
    LOAD_MID = 3'd1,
    LOAD_REM = 3'd2,
    SOLVE    = 3'd3,
    HALT     = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request bit
// at or above i_rr_ptr, wrapping. NUM_CORES must be a power of two.
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]     i_rr_ptr,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_any_grant
);

  int                   w_idx;
  logic [NUM_CORES-1:0] w_rot;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    w_rot       = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = (int'(i_rr_ptr) + k) & (NUM_CORES - 1);
      w_rot = i_req >> w_idx;
      if (!o_any_grant && w_rot[0]) begin
        o_any_grant = 1'b1;
        o_grant_idx = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mining_controller.sv
// mining_controller: sequences a mining job through midstate load,
// remaining-header load, parallel nonce search and claim verification.
// Optional macro MINER_VERIFY_TIMEOUT_EN adds a verify watchdog in HALT.
module mining_controller
  import miner_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int NONCE_W        = 32,
  parameter int MIDSTATE_WORDS = 8,
  parameter int REMAIN_WORDS   = 3,
  parameter int VERIFY_TIMEOUT = 1024,
  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int MAXW   = (MIDSTATE_WORDS > REMAIN_WORDS) ? MIDSTATE_WORDS : REMAIN_WORDS,
  localparam int WIDX_W = (MAXW > 1) ? $clog2(MAXW) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   load_mid_en,
  output logic                   load_rem_en,
  output logic [WIDX_W-1:0]      word_idx,
  output logic                   solve_en,
  output logic [NONCE_W-1:0]     nonce_base,
  input  logic [NUM_CORES-1:0]   core_claim,
  output logic                   halt,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [NONCE_W-1:0]     claim_nonce,
  input  logic                   verify_done,
  input  logic                   verify_pass,
  output logic                   sol_valid,
  output logic                   exhausted,
  output logic [CUR_STATE_W-1:0] cur_state
);

  state_t               r_state, w_state;
  logic [WIDX_W-1:0]    r_word_idx, w_word_idx;
  logic [NONCE_W-1:0]   r_nonce_base, w_nonce_base;
  logic [NUM_CORES-1:0] r_mask, w_mask;
  logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr;
  logic [IDX_W-1:0]     r_grant_idx, w_grant_idx;
  logic [NONCE_W-1:0]   r_claim_nonce, w_claim_nonce;
  logic                 r_sol_valid, w_sol_valid;
  logic                 r_exhausted, w_exhausted;

  logic                 w_accept;
  logic [NONCE_W:0]     w_sum;
  logic [IDX_W-1:0]     w_arb_idx;
  logic                 w_arb_any;
  logic                 w_verify_fail;
  logic                 w_to_expired;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_arb (
    .i_req       (core_claim & ~r_mask),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_idx (w_arb_idx),
    .o_any_grant (w_arb_any)
  );

  assign w_accept = word_valid && word_ready;
  assign w_sum    = {1'b0, r_nonce_base} + (NONCE_W+1)'(NUM_CORES);

`ifdef MINER_VERIFY_TIMEOUT_EN
  localparam int TO_W = $clog2(VERIFY_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Watchdog counts cycles spent in HALT; cleared whenever HALT is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_to_cnt <= '0;
    else if (r_state != HALT) r_to_cnt <= '0;
    else                      r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_to_expired = (r_state == HALT) && (r_to_cnt == TO_W'(VERIFY_TIMEOUT - 1));
`else
  assign w_to_expired = 1'b0;
`endif

  assign w_verify_fail = (verify_done && !verify_pass) || (!verify_done && w_to_expired);

  // Next-state and next-register values; abort overrides every transition.
  always_comb begin
    w_state       = r_state;
    w_word_idx    = r_word_idx;
    w_nonce_base  = r_nonce_base;
    w_mask        = r_mask;
    w_rr_ptr      = r_rr_ptr;
    w_grant_idx   = r_grant_idx;
    w_claim_nonce = r_claim_nonce;
    w_sol_valid   = 1'b0;
    w_exhausted   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state      = LOAD_MID;
          w_nonce_base = '0;
          w_word_idx   = '0;
          w_mask       = '0;
        end
      end
      LOAD_MID: begin
        if (w_accept) begin
          if (r_word_idx == WIDX_W'(MIDSTATE_WORDS - 1)) begin
            w_word_idx = '0;
            w_state    = LOAD_REM;
          end else begin
            w_word_idx = r_word_idx + WIDX_W'(1);
          end
        end
      end
      LOAD_REM: begin
        if (w_accept) begin
          if (r_word_idx == WIDX_W'(REMAIN_WORDS - 1)) begin
            w_word_idx = '0;
            w_state    = SOLVE;
          end else begin
            w_word_idx = r_word_idx + WIDX_W'(1);
          end
        end
      end
      SOLVE: begin
        if (w_arb_any) begin
          // A claim beats a simultaneous overflow; base holds for resume.
          w_grant_idx   = w_arb_idx;
          w_claim_nonce = r_nonce_base + NONCE_W'(w_arb_idx);
          w_state       = HALT;
        end else begin
          w_nonce_base = w_sum[NONCE_W-1:0];
          w_mask       = '0;
          if (w_sum[NONCE_W]) begin
            w_exhausted = 1'b1;
            w_state     = IDLE;
          end
        end
      end
      HALT: begin
        if (verify_done && verify_pass) begin
          w_sol_valid = 1'b1;
          w_state     = IDLE;
        end else if (w_verify_fail) begin
          w_mask   = r_mask | (NUM_CORES'(1) << r_grant_idx);
          w_rr_ptr = IDX_W'((int'(r_grant_idx) + 1) & (NUM_CORES - 1));
          w_state  = SOLVE;
        end
      end
      default: w_state = IDLE;
    endcase
    if (abort) begin
      w_state     = IDLE;
      w_sol_valid = 1'b0;
      w_exhausted = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state;
  end

  // Counters, mask, round-robin pointer, latched grant and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_idx    <= '0;
      r_nonce_base  <= '0;
      r_mask        <= '0;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_claim_nonce <= '0;
      r_sol_valid   <= 1'b0;
      r_exhausted   <= 1'b0;
    end else begin
      r_word_idx    <= w_word_idx;
      r_nonce_base  <= w_nonce_base;
      r_mask        <= w_mask;
      r_rr_ptr      <= w_rr_ptr;
      r_grant_idx   <= w_grant_idx;
      r_claim_nonce <= w_claim_nonce;
      r_sol_valid   <= w_sol_valid;
      r_exhausted   <= w_exhausted;
    end
  end

  assign word_ready  = (r_state == LOAD_MID) || (r_state == LOAD_REM);
  assign load_mid_en = (r_state == LOAD_MID);
  assign load_rem_en = (r_state == LOAD_REM);
  assign solve_en    = (r_state == SOLVE);
  assign halt        = (r_state == HALT);
  assign word_idx    = r_word_idx;
  assign nonce_base  = r_nonce_base;
  assign grant_idx   = r_grant_idx;
  assign claim_nonce = r_claim_nonce;
  assign sol_valid   = r_sol_valid;
  assign exhausted   = r_exhausted;
  assign cur_state   = r_state;

endmodule

// File: tb/tb_mining_controller.sv
// tb_mining_controller: directed-vector bench for mining_controller
// (NUM_CORES=4, NONCE_W=8). Timeout scenario included when
// MINER_VERIFY_TIMEOUT_EN is defined.
module tb_mining_controller;

  localparam int NC  = 4;
  localparam int NW  = 8;
  localparam int MID = 8;
  localparam int REM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, word_valid, verify_done, verify_pass;
  logic [NC-1:0] core_claim;
  logic          word_ready, load_mid_en, load_rem_en, solve_en, halt;
  logic          sol_valid, exhausted;
  logic [2:0]    word_idx;
  logic [NW-1:0] nonce_base, claim_nonce;
  logic [1:0]    grant_idx;
  logic [2:0]    cur_state;

  int n_cmp = 0;
  int n_err = 0;

  mining_controller #(
    .NUM_CORES(NC), .NONCE_W(NW), .MIDSTATE_WORDS(MID),
    .REMAIN_WORDS(REM), .VERIFY_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .word_valid(word_valid), .word_ready(word_ready),
    .load_mid_en(load_mid_en), .load_rem_en(load_rem_en),
    .word_idx(word_idx), .solve_en(solve_en), .nonce_base(nonce_base),
    .core_claim(core_claim), .halt(halt), .grant_idx(grant_idx),
    .claim_nonce(claim_nonce), .verify_done(verify_done),
    .verify_pass(verify_pass), .sol_valid(sol_valid),
    .exhausted(exhausted), .cur_state(cur_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_words();
    word_valid = 1'b1;
    repeat (MID + REM) step();
    word_valid = 1'b0;
  endtask

  task automatic wait_base(input logic [NW-1:0] target, input string tag);
    int n;
    n = 0;
    while (nonce_base != target && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(nonce_base), 32'(target));
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; word_valid = 0;
    verify_done = 0; verify_pass = 0; core_claim = '0;
    repeat (3) step();
    check("rst_state", 32'(cur_state), 0);
    check("rst_ready", 32'(word_ready), 0);
    check("rst_base", 32'(nonce_base), 0);
    check("rst_outs", {27'd0, sol_valid, exhausted, halt, solve_en, load_mid_en}, 0);
    rst = 1'b0;
    step();

    // Load: 8 midstate words, 3 remaining words, then SOLVE stepping by 4.
    do_start();
    check("ld_state_mid", 32'(cur_state), 1);
    word_valid = 1'b1;
    for (int i = 0; i < MID; i++) begin
      check("ld_mid_en", 32'(load_mid_en), 1);
      check("ld_mid_idx", 32'(word_idx), 32'(i));
      step();
    end
    for (int i = 0; i < REM; i++) begin
      check("ld_rem_en", 32'(load_rem_en), 1);
      check("ld_rem_idx", 32'(word_idx), 32'(i));
      step();
    end
    word_valid = 1'b0;
    check("ld_solve", 32'(solve_en), 1);
    check("ld_base0", 32'(nonce_base), 0);
    step();
    check("ld_base4", 32'(nonce_base), 4);
    step();
    check("ld_base8", 32'(nonce_base), 8);

    // Multi-claim with round-robin after a failed verify.
    wait_base(8'h40, "mc_reach40");
    core_claim = 4'b1010;
    step();
    check("mc_halt1", 32'(halt), 1);
    check("mc_grant1", 32'(grant_idx), 1);
    check("mc_nonce41", 32'(claim_nonce), 32'h41);
    verify_done = 1; verify_pass = 0;
    step();
    verify_done = 0;
    check("mc_resume", 32'(cur_state), 3);
    check("mc_base_hold", 32'(nonce_base), 32'h40);
    step();
    check("mc_grant3", 32'(grant_idx), 3);
    check("mc_nonce43", 32'(claim_nonce), 32'h43);
    verify_done = 1; verify_pass = 1;
    step();
    verify_done = 0; verify_pass = 0; core_claim = '0;
    check("mc_solv", 32'(sol_valid), 1);
    check("mc_idle", 32'(cur_state), 0);
    step();
    check("mc_solv_pulse", 32'(sol_valid), 0);

    // Exhaustion: 64 SOLVE cycles with no claims.
    do_start();
    load_words();
    check("ex_base0", 32'(nonce_base), 0);
    repeat (63) step();
    check("ex_baseFC", 32'(nonce_base), 32'hFC);
    check("ex_not_yet", 32'(exhausted), 0);
    step();
    check("ex_pulse", 32'(exhausted), 1);
    check("ex_idle", 32'(cur_state), 0);
    check("ex_wrap", 32'(nonce_base), 0);
    step();
    check("ex_pulse_end", 32'(exhausted), 0);

    // Claim and overflow together: claim wins, exhaustion after resume.
    do_start();
    load_words();
    wait_base(8'hFC, "co_reachFC");
    core_claim = 4'b0001;
    step();
    core_claim = '0;
    check("co_halt", 32'(halt), 1);
    check("co_no_exh", 32'(exhausted), 0);
    check("co_nonce", 32'(claim_nonce), 32'hFC);
    verify_done = 1; verify_pass = 0;
    step();
    verify_done = 0;
    check("co_resume_base", 32'(nonce_base), 32'hFC);
    step();
    check("co_exh", 32'(exhausted), 1);
    check("co_idle", 32'(cur_state), 0);

    // Abort in LOAD_REM at word 1.
    do_start();
    word_valid = 1'b1;
    repeat (MID + 1) step();
    word_valid = 1'b0;
    check("ab_rem_idx1", 32'(word_idx), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_rem_idle", 32'(cur_state), 0);
    check("ab_rem_ready", 32'(word_ready), 0);

    // Abort in HALT together with a passing verify.
    do_start();
    load_words();
    core_claim = 4'b0100;
    step();
    core_claim = '0;
    check("ab_halt", 32'(halt), 1);
    check("ab_grant2", 32'(grant_idx), 2);
    verify_done = 1; verify_pass = 1; abort = 1;
    step();
    verify_done = 0; verify_pass = 0; abort = 0;
    check("ab_idle", 32'(cur_state), 0);
    check("ab_no_sol", 32'(sol_valid), 0);
    step();
    check("ab_no_sol2", 32'(sol_valid), 0);
    do_start();
    check("ab_restart_idx", 32'(word_idx), 0);
    check("ab_restart_mid", 32'(load_mid_en), 1);

`ifdef MINER_VERIFY_TIMEOUT_EN
    // Watchdog: no verify_done, resume after 16 HALT cycles with core masked.
    begin
      int n;
      load_words();
      core_claim = 4'b0011;
      step();
      check("to_grant1", 32'(grant_idx), 1);
      n = 0;
      while (halt && n < 40) begin
        step();
        n++;
      end
      check("to_cycles", 32'(n), 16);
      check("to_solve", 32'(cur_state), 3);
      step();
      check("to_grant0", 32'(grant_idx), 0);
      core_claim = '0;
      abort = 1;
      step();
      abort = 0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
